fetch_unit: RTL and testbench

//  - Instruction fetch stage that sits directly upstream of the instruction decoder.
//  - Holds the PC and issues in-order 32-bit reads to instruction memory over a req/ready + rvalid interface.
//  - Buffers returned words in a small FIFO and presents {instr, pc} to decode with a valid/ready handshake.
//  - Accepts branch/jump redirects from execute and discards any stale in-flight responses.

---
 rtl/fetch_unit.sv | 185 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: PC, in-order imem request issue, request tag queue and decode buffer.
// Optional misaligned-redirect trap is enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic        instr_fault
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    // Outstanding can reach twice the depth: discarded responses plus a full new window.
    localparam int unsigned OW = $clog2(2 * FIFO_DEPTH) + 2;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, FAULT = 2'd2} state_t;
`else
    typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;
`endif

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    fetch_entry_t  buf_q [FIFO_DEPTH];
    logic [31:0]   tag_q [FIFO_DEPTH];
    logic [AW-1:0] buf_wr_q, buf_wr_d, buf_rd_q, buf_rd_d;
    logic [AW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [CW-1:0] buf_cnt_q, buf_cnt_d;
    logic [OW-1:0] outst_q, outst_d, disc_q, disc_d;
    logic [OW-1:0] occupancy;
    logic [31:0]   redir_target;
    logic          redir_misaligned, redir_take;
    logic          accept, resp, resp_drop, resp_keep, push, pop;
    fetch_entry_t  head;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic [31:0]   fault_pc_q, fault_pc_d;
`else
    logic          unused_redir_lsb;
    assign unused_redir_lsb = ^redirect_pc[1:0];
`endif

    // Next-state, issue and output decode.
    always_comb begin
        redir_target     = {redirect_pc[31:2], 2'b00};
        redir_misaligned = 1'b0;
        redir_take       = redirect_valid && (state_q == RUN);
`ifdef FETCH_MISALIGN_TRAP_EN
        redir_target     = redirect_pc;
        redir_misaligned = |redirect_pc[1:0];
        redir_take       = redirect_valid &&
                           ((state_q == RUN) || ((state_q == FAULT) && !redir_misaligned));
`endif
        occupancy = OW'(buf_cnt_q) + (outst_q - disc_q);
        imem_req  = (state_q == RUN) && !redirect_valid && (occupancy < OW'(FIFO_DEPTH));
        imem_addr = pc_q;
        accept    = imem_req && imem_ready;
        resp      = imem_rvalid && (outst_q != '0);
        resp_drop = resp && (disc_q != '0);
        resp_keep = resp && (disc_q == '0);
        push      = resp_keep && !redir_take;
        pop       = instr_ready && (buf_cnt_q != '0);

        state_d   = state_q;
        pc_d      = pc_q;
        buf_wr_d  = buf_wr_q;
        buf_rd_d  = buf_rd_q;
        tag_wr_d  = tag_wr_q;
        tag_rd_d  = tag_rd_q;
        buf_cnt_d = buf_cnt_q + CW'(push) - CW'(pop);
        outst_d   = outst_q + OW'(accept) - OW'(resp);
        disc_d    = disc_q - OW'(resp_drop);
`ifdef FETCH_MISALIGN_TRAP_EN
        fault_pc_d = fault_pc_q;
`endif

        case (state_q)
            BOOT:    state_d = RUN;
`ifdef FETCH_MISALIGN_TRAP_EN
            RUN:     if (redir_take && redir_misaligned) state_d = FAULT;
            FAULT:   if (redir_take) state_d = RUN;
`endif
            default: state_d = state_q;
        endcase

        if (accept) begin
            pc_d     = pc_q + 32'd4;
            tag_wr_d = tag_wr_q + AW'(1);
        end
        if (resp_keep) tag_rd_d = tag_rd_q + AW'(1);
        if (push)      buf_wr_d = buf_wr_q + AW'(1);
        if (pop)       buf_rd_d = buf_rd_q + AW'(1);

        // Redirect flushes buffer and tags; everything still in flight becomes discard.
        if (redir_take) begin
            pc_d      = {redir_target[31:2], 2'b00};
            tag_rd_d  = tag_wr_q;
            buf_rd_d  = buf_wr_q;
            buf_cnt_d = '0;
            disc_d    = outst_q - OW'(resp);
`ifdef FETCH_MISALIGN_TRAP_EN
            if (redir_misaligned) fault_pc_d = redir_target;
`endif
        end

        head        = buf_q[buf_rd_q];
        instr_valid = (buf_cnt_q != '0);
        instr_out   = head.instr;
        instr_pc    = head.pc;
        instr_fault = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        if (state_q == FAULT) begin
            instr_valid = 1'b1;
            instr_out   = NOP_INSTR;
            instr_pc    = fault_pc_q;
            instr_fault = 1'b1;
        end
`endif
    end

    // State and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= BOOT;
            pc_q      <= RESET_PC;
            buf_wr_q  <= '0;
            buf_rd_q  <= '0;
            tag_wr_q  <= '0;
            tag_rd_q  <= '0;
            buf_cnt_q <= '0;
            outst_q   <= '0;
            disc_q    <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_pc_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            buf_wr_q  <= buf_wr_d;
            buf_rd_q  <= buf_rd_d;
            tag_wr_q  <= tag_wr_d;
            tag_rd_q  <= tag_rd_d;
            buf_cnt_q <= buf_cnt_d;
            outst_q   <= outst_d;
            disc_q    <= disc_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_pc_q <= fault_pc_d;
`endif
        end
    end

    // Buffer and tag storage, written only on push/accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                buf_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else begin
            if (push)   buf_q[buf_wr_q] <= '{instr: imem_rdata, pc: tag_q[tag_rd_q]};
            if (accept) tag_q[tag_wr_q] <= pc_q;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (buf_cnt_q == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a queue-level model of the expected fetch/decode streams.
module tb_fetch_unit;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        instr_fault;

    fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_out(instr_out), .instr_pc(instr_pc), .instr_fault(instr_fault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;

    logic [31:0] mem_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] seen_pc[$];
    logic [31:0] seen_dat[$];
    logic [31:0] acc_addr[$];

    logic        mem_ready_s, dec_ready_s, redir_v_s, mem_hold_s;
    logic [31:0] redir_pc_s;

    logic [31:0] exp_fetch_pc, fault_pc_m, prev_addr, prev_pc, prev_out;
    logic        fault_m, flush_q, stall_q, hold_q, mis;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [31:0] eff_target(input logic [31:0] t);
`ifdef FETCH_MISALIGN_TRAP_EN
        return t;
`else
        return {t[31:2], 2'b00};
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    // One clock: drive bench controls and the 1-cycle memory response just after the edge.
    task automatic cycle();
        @(posedge clk);
        #1;
        imem_ready     = mem_ready_s;
        instr_ready    = dec_ready_s;
        redirect_valid = redir_v_s;
        redirect_pc    = redir_pc_s;
        if (!mem_hold_s && (mem_q.size() > 0)) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_fn(mem_q.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    // Model and compare: inputs are stable at negedge and will be seen by the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_fetch_pc = RESET_PC;
            fault_m = 1'b0; flush_q = 1'b0; stall_q = 1'b0; hold_q = 1'b0;
            exp_q.delete(); mem_q.delete();
        end else begin
`ifdef FETCH_MISALIGN_TRAP_EN
            mis = |redirect_pc[1:0];
`else
            mis = 1'b0;
`endif
            if (stall_q && !redirect_valid) begin
                chk("req_held", 32'(imem_req), 32'd1);
                chk("addr_held", imem_addr, prev_addr);
            end
            if (hold_q) begin
                chk("head_valid_held", 32'(instr_valid), 32'd1);
                chk("head_pc_held", instr_pc, prev_pc);
                chk("head_data_held", instr_out, prev_out);
            end
            if (flush_q) chk("flush_valid", 32'(instr_valid), 32'd0);
            if (fault_m) begin
                chk("fault_flag", 32'(instr_fault), 32'd1);
                chk("fault_valid", 32'(instr_valid), 32'd1);
                chk("fault_pc", instr_pc, fault_pc_m);
                chk("fault_nop", instr_out, NOP_INSTR);
                chk("fault_no_req", 32'(imem_req), 32'd0);
            end else begin
                chk("fault_low", 32'(instr_fault), 32'd0);
            end
            chk("live_bound", 32'(exp_q.size() <= int'(FIFO_DEPTH)), 32'd1);

            if (!fault_m && instr_valid && instr_ready) begin
                chk("pop_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    chk("pop_pc", instr_pc, exp_q.pop_front());
                    chk("pop_data", instr_out, mem_fn(instr_pc));
                end
                seen_pc.push_back(instr_pc);
                seen_dat.push_back(instr_out);
            end
            if (imem_req && imem_ready) begin
                chk("fetch_addr", imem_addr, exp_fetch_pc);
                mem_q.push_back(imem_addr);
                exp_q.push_back(imem_addr);
                acc_addr.push_back(imem_addr);
                acc_cnt++;
                exp_fetch_pc = exp_fetch_pc + 32'd4;
            end

            stall_q   = imem_req && !imem_ready;
            hold_q    = instr_valid && !instr_ready && !fault_m && !redirect_valid;
            prev_addr = imem_addr;
            prev_pc   = instr_pc;
            prev_out  = instr_out;

            flush_q = 1'b0;
            if (redirect_valid) begin
                chk("redir_no_req", 32'(imem_req), 32'd0);
                if (!(fault_m && mis)) begin
                    exp_q.delete();
                    if (mis) begin
                        fault_m    = 1'b1;
                        fault_pc_m = redirect_pc;
                    end else begin
                        fault_m      = 1'b0;
                        exp_fetch_pc = eff_target(redirect_pc);
                        flush_q      = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        int n0, na, acc0;
        logic [31:0] a0;
        rst_n = 1'b0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        mem_ready_s = 1'b1; dec_ready_s = 1'b1; redir_v_s = 1'b0; mem_hold_s = 1'b0;
        redir_pc_s = '0;

        repeat (3) @(posedge clk);
        settle();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, RESET_PC);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr_out, 32'd0);
        chk("rst_pc", instr_pc, 32'd0);
        chk("rst_fault", 32'(instr_fault), 32'd0);

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        imem_ready = 1'b1; instr_ready = 1'b1;
        settle();
        chk("boot_no_req", 32'(imem_req), 32'd0);
        cycle();
        settle();
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, 32'h0000_0000);

        // Straight-line fetch.
        repeat (12) cycle();
        settle();
        chk("t1_pc0", (seen_pc.size() > 0) ? seen_pc[0] : 32'hBAD0_BAD1, 32'h0000_0000);
        chk("t1_pc1", (seen_pc.size() > 1) ? seen_pc[1] : 32'hBAD0_BAD1, 32'h0000_0004);
        chk("t1_pc2", (seen_pc.size() > 2) ? seen_pc[2] : 32'hBAD0_BAD1, 32'h0000_0008);
        chk("t1_dat0", (seen_dat.size() > 0) ? seen_dat[0] : 32'hBAD0_BAD1, 32'hC0DE_0000);
        chk("t1_dat2", (seen_dat.size() > 2) ? seen_dat[2] : 32'hBAD0_BAD1, 32'hC0DE_0008);

        // Decoder stall fills the buffer exactly.
        dec_ready_s = 1'b0;
        repeat (10) cycle();
        settle();
        chk("t2_no_req", 32'(imem_req), 32'd0);
        chk("t2_valid", 32'(instr_valid), 32'd1);
        chk("t2_buffered", 32'(exp_q.size()), 32'(FIFO_DEPTH));
        chk("t2_mem_idle", 32'(mem_q.size()), 32'd0);
        n0 = seen_pc.size();
        dec_ready_s = 1'b1;
        repeat (6) cycle();
        settle();
        chk("t2_resumed", 32'(seen_pc.size() >= n0 + 2), 32'd1);

        // Two in flight, then redirect: both responses must be dropped.
        mem_hold_s = 1'b1;
        repeat (6) cycle();
        settle();
        chk("t3_inflight", 32'(mem_q.size()), 32'd2);
        chk("t3_no_req", 32'(imem_req), 32'd0);
        chk("t3_empty", 32'(instr_valid), 32'd0);
        redir_v_s = 1'b1; redir_pc_s = 32'h0000_0100;
        cycle();
        settle();
        n0 = seen_pc.size();
        redir_v_s = 1'b0; mem_hold_s = 1'b0;
        repeat (10) cycle();
        settle();
        chk("t3_pc", (seen_pc.size() > n0) ? seen_pc[n0] : 32'hBAD0_BAD1, 32'h0000_0100);
        chk("t3_dat", (seen_dat.size() > n0) ? seen_dat[n0] : 32'hBAD0_BAD1, 32'hC0DE_0100);

        // Memory back-pressure.
        mem_ready_s = 1'b0;
        cycle();
        settle();
        a0 = imem_addr; acc0 = acc_cnt;
        repeat (5) cycle();
        settle();
        chk("t4_addr_const", imem_addr, a0);
        chk("t4_req_high", 32'(imem_req), 32'd1);
        chk("t4_no_accept", 32'(acc_cnt), 32'(acc0));
        mem_ready_s = 1'b1;
        cycle();
        settle();
        chk("t4_one_accept", 32'(acc_cnt), 32'(acc0 + 1));
        chk("t4_accept_addr", acc_addr[acc_addr.size() - 1], a0);
        repeat (4) cycle();

        // PC wrap.
        redir_v_s = 1'b1; redir_pc_s = 32'hFFFF_FFFC;
        cycle();
        settle();
        n0 = seen_pc.size(); na = acc_addr.size();
        redir_v_s = 1'b0;
        repeat (8) cycle();
        settle();
        chk("t5_addr0", (acc_addr.size() > na) ? acc_addr[na] : 32'hBAD0_BAD1, 32'hFFFF_FFFC);
        chk("t5_addr1", (acc_addr.size() > na + 1) ? acc_addr[na + 1] : 32'hBAD0_BAD1, 32'h0000_0000);
        chk("t5_pc0", (seen_pc.size() > n0) ? seen_pc[n0] : 32'hBAD0_BAD1, 32'hFFFF_FFFC);
        chk("t5_pc1", (seen_pc.size() > n0 + 1) ? seen_pc[n0 + 1] : 32'hBAD0_BAD1, 32'h0000_0000);

        // Misaligned redirect.
        redir_v_s = 1'b1; redir_pc_s = 32'h0000_0102;
        cycle();
        settle();
        na = acc_addr.size();
        redir_v_s = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        cycle();
        settle();
        chk("t6_fault", 32'(instr_fault), 32'd1);
        chk("t6_pc", instr_pc, 32'h0000_0102);
        chk("t6_nop", instr_out, 32'h0000_0013);
        chk("t6_valid", 32'(instr_valid), 32'd1);
        repeat (4) cycle();
        settle();
        chk("t6_no_fetch", 32'(acc_addr.size()), 32'(na));
        redir_v_s = 1'b1; redir_pc_s = 32'h0000_0200;
        cycle();
        settle();
        na = acc_addr.size();
        redir_v_s = 1'b0;
        repeat (6) cycle();
        settle();
        chk("t6_resume_addr", (acc_addr.size() > na) ? acc_addr[na] : 32'hBAD0_BAD1, 32'h0000_0200);
        chk("t6_fault_clear", 32'(instr_fault), 32'd0);
`else
        repeat (6) cycle();
        settle();
        chk("t6_aligned_addr", (acc_addr.size() > na) ? acc_addr[na] : 32'hBAD0_BAD1, 32'h0000_0100);
        chk("t6_fault_tied", 32'(instr_fault), 32'd0);
`endif
        repeat (4) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
